cursor_input: RTL

- Upstream input stage for the board-game controller.
- Synchronises and debounces the five raw push-buttons (up, down, left, right, confirm) and maintains a wrap-around board cursor.
- On confirm, offers the selected (x, y) move to the game controller over a valid/ready handshake.
- The controller enables the block during a human player's turn and can reload the cursor, for example after an undo.

---
 rtl/cursor_input.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cursor_input.sv
// cursor_input: button front end and board cursor for the game controller.
// Synchronises and debounces five raw buttons, generates press and auto-repeat
// events, moves a wrap-around (x, y) cursor, and offers the cursor position as
// a move over a valid/ready handshake when confirm is pressed.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_btn[4:0]            raw buttons: [0]=up [1]=down [2]=left [3]=right [4]=confirm
//   i_enable              human turn; cursor input allowed
//   i_cursor_load         one-cycle cursor overwrite with i_load_x/i_load_y (clamped)
//   o_cur_x, o_cur_y      current cursor
//   o_move_valid          move offer pending; o_move_x/o_move_y hold the offered move
//   i_move_ready          controller accepts the offer
//   o_busy                offer outstanding
module cursor_input #(
  parameter int unsigned BOARD_W         = 15,
  parameter int unsigned BOARD_H         = 15,
  parameter int unsigned COORD_W         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_INIT     = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [4:0]         i_btn,
  input  logic               i_enable,
  input  logic               i_cursor_load,
  input  logic [COORD_W-1:0] i_load_x,
  input  logic [COORD_W-1:0] i_load_y,
  output logic [COORD_W-1:0] o_cur_x,
  output logic [COORD_W-1:0] o_cur_y,
  output logic               o_move_valid,
  input  logic               i_move_ready,
  output logic [COORD_W-1:0] o_move_x,
  output logic [COORD_W-1:0] o_move_y,
  output logic               o_busy
);

  localparam int unsigned BTN_UP      = 0;
  localparam int unsigned BTN_DOWN    = 1;
  localparam int unsigned BTN_LEFT    = 2;
  localparam int unsigned BTN_RIGHT   = 3;
  localparam int unsigned BTN_CONFIRM = 4;

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(REPEAT_INIT + 1);

  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_FIRE   = HOLD_W'(REPEAT_INIT);
  // After a repeat fires, restart RATE cycles short of HOLD_FIRE so the next
  // repeat lands exactly REPEAT_RATE cycles later.
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(REPEAT_INIT - REPEAT_RATE + 1);
  localparam logic [COORD_W-1:0] MAX_X       = COORD_W'(BOARD_W - 1);
  localparam logic [COORD_W-1:0] MAX_Y       = COORD_W'(BOARD_H - 1);
  localparam logic [COORD_W-1:0] MID_X       = COORD_W'(BOARD_W / 2);
  localparam logic [COORD_W-1:0] MID_Y       = COORD_W'(BOARD_H / 2);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_OFFER} state_e;

  logic [4:0]         r_sync1, r_sync2, r_stable, r_stable_prev;
  logic [DB_W-1:0]    r_db_cnt [5];
  logic [HOLD_W-1:0]  r_hold   [4];
  state_e             r_state;
  logic [COORD_W-1:0] r_cur_x, r_cur_y, r_move_x, r_move_y;

  logic [4:0]         w_stable_nxt;
  logic [DB_W-1:0]    w_db_cnt_nxt [5];
  logic [HOLD_W-1:0]  w_hold_nxt   [4];
  logic [3:0]         w_rep;
  logic [4:0]         w_press;
  logic [3:0]         w_dir_ev;
  state_e             w_state_nxt;
  logic [COORD_W-1:0] w_cur_x_nxt, w_cur_y_nxt, w_move_x_nxt, w_move_y_nxt;
  logic [COORD_W-1:0] w_step_x, w_step_y, w_clamp_x, w_clamp_y;

  // Debounce: stable level follows the synced level only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_stable_nxt[i] = r_stable[i];
      w_db_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_prev;

  // Auto-repeat on direction buttons; hold count is 0 in the press cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_rep[i]      = 1'b0;
      w_hold_nxt[i] = '0;
      if (r_stable[i]) begin
        if (r_hold[i] == HOLD_FIRE) begin
          w_rep[i]      = 1'b1;
          w_hold_nxt[i] = HOLD_RELOAD;
        end else begin
          w_hold_nxt[i] = r_hold[i] + HOLD_W'(1);
        end
      end
    end
  end

  assign w_dir_ev = w_press[3:0] | w_rep;

  // Cursor step with wrap-around; opposing directions cancel.
  always_comb begin
    w_step_x = r_cur_x;
    w_step_y = r_cur_y;
    if (w_dir_ev[BTN_RIGHT] && !w_dir_ev[BTN_LEFT]) begin
      w_step_x = (r_cur_x == MAX_X) ? '0 : r_cur_x + COORD_W'(1);
    end else if (w_dir_ev[BTN_LEFT] && !w_dir_ev[BTN_RIGHT]) begin
      w_step_x = (r_cur_x == '0) ? MAX_X : r_cur_x - COORD_W'(1);
    end
    if (w_dir_ev[BTN_DOWN] && !w_dir_ev[BTN_UP]) begin
      w_step_y = (r_cur_y == MAX_Y) ? '0 : r_cur_y + COORD_W'(1);
    end else if (w_dir_ev[BTN_UP] && !w_dir_ev[BTN_DOWN]) begin
      w_step_y = (r_cur_y == '0) ? MAX_Y : r_cur_y - COORD_W'(1);
    end
  end

  assign w_clamp_x = (i_load_x > MAX_X) ? MAX_X : i_load_x;
  assign w_clamp_y = (i_load_y > MAX_Y) ? MAX_Y : i_load_y;

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_x_nxt  = r_cur_x;
    w_cur_y_nxt  = r_cur_y;
    w_move_x_nxt = r_move_x;
    w_move_y_nxt = r_move_y;
    unique case (r_state)
      S_IDLE: begin
        if (i_cursor_load) begin
          w_cur_x_nxt = w_clamp_x;
          w_cur_y_nxt = w_clamp_y;
        end
        if (i_enable) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (i_cursor_load) begin
          w_cur_x_nxt = w_clamp_x;
          w_cur_y_nxt = w_clamp_y;
        end else begin
          w_cur_x_nxt = w_step_x;
          w_cur_y_nxt = w_step_y;
        end
        // Losing the turn wins over a simultaneous confirm.
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_press[BTN_CONFIRM]) begin
          w_move_x_nxt = r_cur_x;
          w_move_y_nxt = r_cur_y;
          w_state_nxt  = S_OFFER;
        end
      end
      S_OFFER: begin
        if (i_move_ready) begin
          w_state_nxt = i_enable ? S_SELECT : S_IDLE;
        end else if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_stable      <= '0;
      r_stable_prev <= '0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
      for (int i = 0; i < 4; i++) r_hold[i] <= '0;
      r_state       <= S_IDLE;
      r_cur_x       <= MID_X;
      r_cur_y       <= MID_Y;
      r_move_x      <= '0;
      r_move_y      <= '0;
    end else begin
      r_sync1       <= i_btn;
      r_sync2       <= r_sync1;
      r_stable      <= w_stable_nxt;
      r_stable_prev <= r_stable;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
      for (int i = 0; i < 4; i++) r_hold[i] <= w_hold_nxt[i];
      r_state       <= w_state_nxt;
      r_cur_x       <= w_cur_x_nxt;
      r_cur_y       <= w_cur_y_nxt;
      r_move_x      <= w_move_x_nxt;
      r_move_y      <= w_move_y_nxt;
    end
  end

  assign o_cur_x      = r_cur_x;
  assign o_cur_y      = r_cur_y;
  assign o_move_x     = r_move_x;
  assign o_move_y     = r_move_y;
  assign o_move_valid = (r_state == S_OFFER);
  assign o_busy       = (r_state == S_OFFER);

endmodule
